// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an NDIG-digit seven-segment display.
// Each digit gets a slot of DIV clocks. The first BLANK clocks of every slot
// are dark to stop ghosting. New digit values are double-buffered, so a
// frame is always shown whole.
module seg7_scan #(
    parameter int NDIG           = 4,
    parameter int DIV            = 50000,
    parameter int BLANK          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              lz_en,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int              PW      = $clog2(DIV);
    localparam int              IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   PLAST   = PW'(DIV - 1);
    localparam logic [IW-1:0]   ILAST   = IW'(NDIG - 1);
    localparam logic [6:0]      SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic            DP_INV  = SEG_ACTIVE_LOW;
    localparam logic [NDIG-1:0] AN_INV  = {NDIG{AN_ACTIVE_LOW}};

    // Active-high hex glyph, segment a in bit 6
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    logic [PW-1:0]     pcnt;
    logic [IW-1:0]     idx;
    logic              tick;
    logic              wrap;

    logic [4*NDIG-1:0] pend_val;
    logic [NDIG-1:0]   pend_dp;
    logic              pend_lz;
    logic              pend_valid;
    logic [4*NDIG-1:0] disp_val;
    logic [NDIG-1:0]   disp_dp;
    logic              disp_lz;

    logic              vld_p0;
    logic [3:0]        nib_p0;
    logic              dsel_p0;
    logic              supp_p0;
    logic              allz;
    logic [NDIG-1:0]   an_p0;
    logic [6:0]        seg_p0;
    logic              dp_p0;

    assign tick = en && (pcnt == PLAST);
    assign wrap = tick && (idx == ILAST);

    // Slot prescaler and digit index; both freeze while en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (en) begin
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == ILAST) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Double buffer: loads park in pending, display swaps only at the frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_lz    <= 1'b0;
        end else if (load && wrap) begin
            disp_val   <= value;
            disp_dp    <= dp_in;
            disp_lz    <= lz_en;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_lz    <= lz_en;
            pend_valid <= 1'b1;
        end else if (wrap && pend_valid) begin
            disp_val   <= pend_val;
            disp_dp    <= pend_dp;
            disp_lz    <= pend_lz;
            pend_valid <= 1'b0;
        end
    end

    // ---- stage p0: decode current digit, blanking and zero suppression ----
    always_comb begin
        nib_p0  = '0;
        dsel_p0 = 1'b0;
        supp_p0 = 1'b0;
        an_p0   = '0;
        allz    = 1'b1;
        // Scan from the top digit down so allz means "this and all above are 0"
        for (int k = NDIG - 1; k >= 0; k--) begin
            allz = allz && (disp_val[4*k +: 4] == 4'd0);
            if (idx == IW'(k)) begin
                nib_p0   = disp_val[4*k +: 4];
                dsel_p0  = disp_dp[k];
                an_p0[k] = 1'b1;
                supp_p0  = disp_lz && allz && (k != 0);
            end
        end
        vld_p0 = en && (int'(pcnt) >= BLANK);
        seg_p0 = (vld_p0 && !supp_p0) ? glyph(nib_p0) : 7'd0;
        dp_p0  = vld_p0 && dsel_p0;
        if (!vld_p0) begin
            an_p0 = '0;
        end
    end

    // ---- stage p1: registered pins with polarity applied ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_INV;
            dp         <= DP_INV;
            an         <= AN_INV;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_p0 ^ SEG_INV;
            dp         <= dp_p0 ^ DP_INV;
            an         <= an_p0 ^ AN_INV;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: bench for seg7_scan with NDIG=4, DIV=4, BLANK=1, active-low pins.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n, en, load, lz_en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan #(
        .NDIG(4), .DIV(4), .BLANK(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .dp_in(dp_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;
    obs_t sb[$];

    // Active-high glyphs, segment a in bit 6
    logic [6:0] glyph_h [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model state
    int          m_pcnt, m_idx;
    logic [15:0] m_dval, m_pval;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_dlz, m_plz, m_pv;

    // Inputs applied on the next step
    logic        s_en;
    logic [15:0] s_val;
    logic [3:0]  s_dp;
    logic        s_lz;

    typedef struct {
        string       name;
        logic [15:0] val;
        logic [3:0]  dpv;
        logic        lz;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } spot_t;
    spot_t spots[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pcnt = 0; m_idx = 0;
        m_dval = '0; m_pval = '0; m_ddp = '0; m_pdp = '0;
        m_dlz = 1'b0; m_plz = 1'b0; m_pv = 1'b0;
        sb.delete();
    endtask

    // One clock: drive at negedge, predict, compare just after posedge
    task automatic step(input logic ld);
        obs_t       e;
        obs_t       got;
        logic [3:0] nib;
        logic       supp;
        @(negedge clk);
        en = s_en; load = ld; value = s_val; dp_in = s_dp; lz_en = s_lz;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        if (s_en && m_pcnt >= 1) begin
            e.an = ~(4'b0001 << m_idx);
            nib  = m_dval[4*m_idx +: 4];
            supp = m_dlz && (m_idx > 0) && ((m_dval >> (4*m_idx)) == 16'h0000);
            e.seg = supp ? 7'h7F : ~glyph_h[nib];
            e.dp  = ~m_ddp[m_idx];
        end
        e.fd = s_en && (m_pcnt == 3) && (m_idx == 3);
        sb.push_back(e);
        if (ld && e.fd) begin
            m_dval = s_val; m_ddp = s_dp; m_dlz = s_lz; m_pv = 1'b0;
        end else if (ld) begin
            m_pval = s_val; m_pdp = s_dp; m_plz = s_lz; m_pv = 1'b1;
        end else if (e.fd && m_pv) begin
            m_dval = m_pval; m_ddp = m_pdp; m_dlz = m_plz; m_pv = 1'b0;
        end
        if (s_en) begin
            if (m_pcnt == 3) begin
                m_pcnt = 0;
                m_idx  = (m_idx + 1) % 4;
            end else begin
                m_pcnt++;
            end
        end
        @(posedge clk);
        #1;
        got = obs_t'({an, seg, dp, frame_done});
        e   = sb.pop_front();
        chk("scoreboard", 32'(got), 32'(e));
    endtask

    task automatic wait_fd(input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            step(1'b0);
            n++;
        end
        chk({name, "_fd_seen"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int  n;
        logic seen, found;

        spots.push_back('{"12AF_d0",   16'h12AF, 4'h0, 1'b0, 4'b1110, 7'b0111000, 1'b1});
        spots.push_back('{"12AF_d1",   16'h12AF, 4'h0, 1'b0, 4'b1101, 7'b0001000, 1'b1});
        spots.push_back('{"12AF_d3",   16'h12AF, 4'h0, 1'b0, 4'b0111, 7'b1001111, 1'b1});
        spots.push_back('{"0050lz_d3", 16'h0050, 4'h0, 1'b1, 4'b0111, 7'b1111111, 1'b1});
        spots.push_back('{"0050lz_d2", 16'h0050, 4'h0, 1'b1, 4'b1011, 7'b1111111, 1'b1});
        spots.push_back('{"0050lz_d1", 16'h0050, 4'h0, 1'b1, 4'b1101, 7'b0100100, 1'b1});
        spots.push_back('{"0050lz_d0", 16'h0050, 4'h0, 1'b1, 4'b1110, 7'b0000001, 1'b1});
        spots.push_back('{"0050_d3",   16'h0050, 4'h0, 1'b0, 4'b0111, 7'b0000001, 1'b1});
        spots.push_back('{"0000lz_d0", 16'h0000, 4'h0, 1'b1, 4'b1110, 7'b0000001, 1'b1});
        spots.push_back('{"0000lz_dp2",16'h0000, 4'h4, 1'b1, 4'b1011, 7'b1111111, 1'b0});
        spots.push_back('{"0903lz_d2", 16'h0903, 4'h0, 1'b1, 4'b1011, 7'b0000100, 1'b1});
        spots.push_back('{"0903lz_d1", 16'h0903, 4'h0, 1'b1, 4'b1101, 7'b0000001, 1'b1});
        spots.push_back('{"7D6B_d0",   16'h7D6B, 4'h1, 1'b0, 4'b1110, 7'b1100000, 1'b0});
        spots.push_back('{"C4E8_d1",   16'hC4E8, 4'h0, 1'b0, 4'b1101, 7'b0110000, 1'b1});
        spots.push_back('{"C4E8_d3",   16'hC4E8, 4'h0, 1'b0, 4'b0111, 7'b0110001, 1'b1});

        rst_n = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
        s_en = 1'b0; s_val = '0; s_dp = '0; s_lz = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_fd", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0);
        step(1'b0);
        s_en = 1'b1;

        // Table of digit spot checks
        foreach (spots[i]) begin
            s_val = spots[i].val; s_dp = spots[i].dpv; s_lz = spots[i].lz;
            step(1'b1);
            seen  = frame_done;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                step(1'b0);
                if (seen && an == spots[i].an) begin
                    found = 1'b1;
                    chk({spots[i].name, "_seg"}, 32'(seg), 32'(spots[i].seg));
                    chk({spots[i].name, "_dp"}, 32'(dp), 32'(spots[i].dp));
                end
                if (frame_done) seen = 1'b1;
            end
            chk({spots[i].name, "_found"}, 32'(found), 32'd1);
        end

        // Slot shape: one blank clock then three lit clocks; frame period 16
        s_val = 16'h12AF; s_dp = 4'h0; s_lz = 1'b0;
        step(1'b1);
        wait_fd("slot");
        step(1'b0);
        chk("slot_blank_an", 32'(an), 32'hF);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            chk("slot_lit_an", 32'(an), 32'b1110);
            chk("slot_lit_seg", 32'(seg), 32'b0111000);
        end
        wait_fd("period");
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                step(1'b0);
                n++;
            end while (frame_done !== 1'b1 && n < 40);
            chk("fd_period", 32'(n), 32'd16);
        end

        // Mid-frame load must not disturb the frame in progress
        s_val = 16'h2222;
        step(1'b1);
        wait_fd("r2222");
        for (int k = 0; k < 5; k++) step(1'b0);
        s_val = 16'h1111;
        step(1'b1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0);
            if (an != 4'hF) chk("old_frame_seg", 32'(seg), 32'b0010010);
            if (frame_done) break;
        end
        chk("new_frame_fd", 32'(frame_done), 32'd1);
        step(1'b0);
        chk("new_frame_blank", 32'(an), 32'hF);
        step(1'b0);
        chk("new_frame_an", 32'(an), 32'b1110);
        chk("new_frame_seg", 32'(seg), 32'b1001111);

        // Load on the wrap tick goes straight to display
        n = 0;
        while (!(m_pcnt == 3 && m_idx == 3) && n < 40) begin
            step(1'b0);
            n++;
        end
        s_val = 16'h4444;
        step(1'b1);
        chk("wrapload_fd", 32'(frame_done), 32'd1);
        step(1'b0);
        step(1'b0);
        chk("wrapload_an", 32'(an), 32'b1110);
        chk("wrapload_seg", 32'(seg), 32'b1001100);

        // Scan pause mid-slot with a load while paused
        n = 0;
        while (!(m_pcnt == 2 && m_idx == 1) && n < 40) begin
            step(1'b0);
            n++;
        end
        s_en = 1'b0;
        s_val = 16'h3333;
        for (int k = 0; k < 10; k++) begin
            step(k == 3);
            chk("pause_an", 32'(an), 32'hF);
            chk("pause_fd", 32'(frame_done), 32'd0);
        end
        s_en = 1'b1;
        wait_fd("resume");
        step(1'b0);
        step(1'b0);
        chk("resume_an", 32'(an), 32'b1110);
        chk("resume_seg", 32'(seg), 32'b0000110);

        // Reset mid-slot at digit 2
        n = 0;
        while (!(m_pcnt == 2 && m_idx == 2) && n < 40) begin
            step(1'b0);
            n++;
        end
        chk("pre_rst_an", 32'(an), 32'b1011);
        rst_n = 1'b0;
        #2;
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'd1);
        chk("midrst_fd", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0);
        chk("after_rst_blank", 32'(an), 32'hF);
        step(1'b0);
        chk("after_rst_an", 32'(an), 32'b1110);
        chk("after_rst_seg", 32'(seg), 32'b0000001);
        for (int k = 0; k < 20; k++) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV, default 50000: clocks per digit slot, legal value >=2.
REQ-003 Parameter BLANK, default 2: anti-ghost clocks at the start of each slot, legal range 0..DIV-1.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1: when 1, seg and dp are inverted at the pins.
REQ-005 Parameter AN_ACTIVE_LOW, default 1: when 1, the an outputs are inverted at the pins.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port en, input, 1 bit: scan enable.
REQ-009 Port load, input, 1 bit: one-clock strobe that captures value, dp_in and lz_en.
REQ-010 Port value, input, 4*NDIG bits: hex nibbles; nibble k drives digit k, and digit 0 is least significant.
REQ-011 Port dp_in, input, NDIG bits: decimal point request per digit.
REQ-012 Port lz_en, input, 1 bit: enables leading-zero suppression.
REQ-013 Port seg, output, 7 bits: segments {a,b,c,d,e,f,g}, with a in bit 6; registered.
REQ-014 Port dp, output, 1 bit: decimal point; registered.
REQ-015 Port an, output, NDIG bits: digit enables, one-hot when active; registered.
REQ-016 Port frame_done, output, 1 bit: one-clock pulse when the scan wraps; registered.

Function
REQ-017 Active-high glyph table:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
REQ-018 Prescaler pcnt counts 0..DIV-1 while en=1; a tick occurs at pcnt==DIV-1, and pcnt then wraps to 0.
REQ-019 On a tick, digit index idx advances by one and wraps from NDIG-1 to 0; for NDIG=1, idx stays 0.
REQ-020 frame_done = 1 for exactly the clock after the tick on which idx wraps NDIG-1 -> 0.
REQ-021 pend_valid register:
- load=1 copies value, dp_in and lz_en into the pending registers and sets pend_valid.
- A second load before the wrap overwrites the pending registers; only the last load is applied.
REQ-022 Display registers take the pending contents only on an idx wrap tick with pend_valid=1, which then clears pend_valid; the frame in progress never changes mid-scan.
REQ-023 When load coincides with a wrap tick, the loaded inputs go straight to the display registers and pend_valid remains 0.
REQ-024 Output registers are updated every clock from the current idx/pcnt, with one clock of latency:
- an: bit idx active, all other bits inactive.
- seg: glyph of display nibble idx.
- dp: display dp bit idx.
REQ-025 When pcnt < BLANK, an, seg and dp are all inactive.
REQ-026 Leading-zero suppression applies when the display lz_en is 1:
- Digit k>0 is suppressed when it and every digit above it are 0.
- A suppressed digit drives seg inactive with an still active.
- dp follows dp_in regardless of suppression.
- Digit 0 is never suppressed.
REQ-027 When en=0:
- pcnt and idx hold.
- an, seg, dp are inactive and frame_done is 0.
- load still operates; a held pending load is applied at the next wrap after en returns to 1.
REQ-028 Pin polarity: seg and dp are inverted when SEG_ACTIVE_LOW=1, and an is inverted when AN_ACTIVE_LOW=1.
REQ-029 Values of value wider or narrower than 4*NDIG are not supported; width is fixed by NDIG.

Reset
REQ-030 On rst_n=0, immediately and regardless of clk:
- pcnt=0, idx=0.
- Display and pending registers = 0, pend_valid=0.
- an, seg and dp at inactive pin level; frame_done=0.
REQ-031 After rst_n rises, the first tick occurs DIV clocks after the first clock edge with en=1.

Verification
All scenarios use NDIG=4, DIV=4, BLANK=1, both ACTIVE_LOW=1.
REQ-032 Reset asserted -> an=1111, seg=1111111, dp=1, frame_done=0, asynchronously.
REQ-033 load value=16'h12AF, dp_in=0000, en=1:
- After the next wrap, the digit-0 slot shows seg=0111000, an=1110 for 3 clocks, preceded by 1 blank clock with an=1111.
- frame_done pulses every 16 clocks.
REQ-034 lz_en=1, value=16'h0050:
- Digit-3 and digit-2 slots show seg=1111111 with an active.
- Digit 1 shows 0100100; digit 0 shows 0000001.
REQ-035 load 16'h1111 mid-frame while 16'h2222 is displayed -> 2222 glyphs persist until the wrap; 1111 appears from digit 0 of the next frame.
REQ-036 rst_n pulsed low mid-slot with idx=2 -> idx=0, outputs inactive; scanning restarts from digit 0 with a cleared display.
REQ-037 en=0 for 10 clocks mid-slot -> an=1111 throughout; pcnt and idx resume from their held values.
